// File: rtl/gen_coherente.sv
// gen_coherente: replays an M-point waveform table as a frame-aligned periodic sample stream,
// N frames per run (N=0 runs until a frame-aligned stop).
module gen_coherente #(
    parameter int M  = 32,
    parameter int N  = 64,
    parameter int AW = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic signed [31:0] wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic [15:0]        div,
    output logic               data_out_valid,
    output logic signed [31:0] data_out,
    output logic               frame_start,
    output logic               busy,
    output logic               done,
    output logic [15:0]        frames_sent
);
    typedef enum logic {IDLE, PLAY} state_t;
    localparam logic [15:0]   LAST_FRAME = 16'(N - 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(M - 1);
    state_t state, state_nx;
    logic signed [31:0] tbl [M];
    logic [AW-1:0] index;
    logic [15:0] div_cnt, div_r;
    logic stop_pend, tick, last;
    assign tick = state == PLAY && div_cnt == div_r;
    // a run may only end on the last sample of a frame
    assign last = tick && index == LAST_IDX && (stop_pend || (N != 0 && frames_sent == LAST_FRAME));
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start ? PLAY : IDLE) : (last ? IDLE : PLAY);
    end
    // table is locked while playing; not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) tbl[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_valid <= 1'b0;
            data_out       <= '0;
            frame_start    <= 1'b0;
            done           <= 1'b0;
            frames_sent    <= '0;
            index          <= '0;
            div_cnt        <= '0;
            div_r          <= '0;
            stop_pend      <= 1'b0;
        end else begin
            data_out_valid <= tick;
            frame_start    <= tick && index == '0;
            done           <= last;
            if (tick) begin
                data_out <= tbl[index];
                index    <= index + 1'b1;
                div_cnt  <= '0;
                if (index == LAST_IDX && frames_sent != 16'hFFFF) frames_sent <= frames_sent + 16'd1;
            end else if (state == PLAY) begin
                div_cnt <= div_cnt + 16'd1;
            end
            if (state == IDLE && start) begin
                index       <= '0;
                div_cnt     <= '0;
                frames_sent <= '0;
                div_r       <= div;
                stop_pend   <= 1'b0;
            end else if (state == PLAY && stop) begin
                stop_pend <= 1'b1;
            end
        end
    end
endmodule
